// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among N_REQ requesters.
// Owns the trigger/ready handshake, the readback capture and the transfer timeout.
module spi_arbiter #(
    parameter int N_REQ          = 3,
    parameter int TRANSFER_SIZE  = 8,
    parameter int N_SDI          = 1,
    parameter int TRIG_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [N_REQ-1:0]               req_in,
    input  logic [N_REQ*TRANSFER_SIZE-1:0] req_data_in,
    output logic [N_REQ-1:0]               grant_out,
    output logic [N_REQ-1:0]               ack_out,
    output logic                           err_out,
    output logic [N_SDI*TRANSFER_SIZE-1:0] rsp_data_out,
    output logic                           busy_out,
    output logic                           spi_trigger_out,
    output logic [TRANSFER_SIZE-1:0]       spi_data_out,
    input  logic [N_SDI*TRANSFER_SIZE-1:0] spi_data_in,
    input  logic                           spi_ready_in
);

    localparam int          PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int          TW = $clog2(TRIG_CYCLES + 1);
    localparam int          CW = 20;
    localparam int          RW = N_SDI * TRANSFER_SIZE;
    localparam int unsigned NR = N_REQ;
    localparam int unsigned NT = TRANSFER_SIZE;

    localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRIG      = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    logic                     rdy_meta_q, rdy_s_q;
    logic [2:0]               state_q, state_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic [PW-1:0]            owner_q, owner_d;
    logic [N_REQ-1:0]         grant_q, grant_d;
    logic [N_REQ-1:0]         ack_q, ack_d;
    logic                     err_q, err_d;
    logic [RW-1:0]            rsp_q, rsp_d;
    logic                     busy_q, busy_d;
    logic                     trig_q, trig_d;
    logic [TRANSFER_SIZE-1:0] data_q, data_d;
    logic [TW-1:0]            trig_cnt_q, trig_cnt_d;
    logic [CW-1:0]            to_cnt_q, to_cnt_d;
    logic                     to_flag_q, to_flag_d;

    logic [PW-1:0]    sel_idx;
    logic             sel_vld;
    int unsigned      rr_idx;
    logic [N_REQ-1:0] req_sh;
    logic             to_hit;

    // Scan starts one past the last owner, so the previous winner ranks last.
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        rr_idx  = 0;
        req_sh  = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            rr_idx = (32'(ptr_q) + k) % NR;
            req_sh = req_in >> rr_idx;
            if (!sel_vld && req_sh[0]) begin
                sel_vld = 1'b1;
                sel_idx = PW'(rr_idx);
            end
        end
    end

    assign to_hit = (to_cnt_q == TO_LAST);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        ack_d      = '0;
        err_d      = 1'b0;
        rsp_d      = rsp_q;
        busy_d     = busy_q;
        trig_d     = trig_q;
        data_d     = data_q;
        trig_cnt_d = trig_cnt_q;
        to_cnt_d   = to_cnt_q;
        to_flag_d  = to_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (rdy_s_q && sel_vld) begin
                    grant_d    = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
                    owner_d    = sel_idx;
                    data_d     = TRANSFER_SIZE'(req_data_in >> (32'(sel_idx) * NT));
                    busy_d     = 1'b1;
                    trig_cnt_d = '0;
                    to_cnt_d   = '0;
                    to_flag_d  = 1'b0;
                    state_d    = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (to_hit) begin
                    trig_d    = 1'b0;
                    to_flag_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + CW'(1);
                    if (trig_cnt_q == TRIG_LAST) begin
                        trig_d  = 1'b0;
                        state_d = ST_WAIT_BUSY;
                    end else begin
                        trig_d     = 1'b1;
                        trig_cnt_d = trig_cnt_q + TW'(1);
                    end
                end
            end
            ST_WAIT_BUSY: begin
                if (to_hit) begin
                    to_flag_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + CW'(1);
                    if (!rdy_s_q) state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (to_hit) begin
                    to_flag_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + CW'(1);
                    if (rdy_s_q) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ack_d   = grant_q;
                err_d   = to_flag_q;
                rsp_d   = to_flag_q ? '0 : spi_data_in;
                ptr_d   = owner_q;
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rdy_meta_q <= 1'b0;
            rdy_s_q    <= 1'b0;
            state_q    <= ST_IDLE;
            ptr_q      <= PW'(N_REQ - 1);
            owner_q    <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            rsp_q      <= '0;
            busy_q     <= 1'b0;
            trig_q     <= 1'b0;
            data_q     <= '0;
            trig_cnt_q <= '0;
            to_cnt_q   <= '0;
            to_flag_q  <= 1'b0;
        end else begin
            rdy_meta_q <= spi_ready_in;
            rdy_s_q    <= rdy_meta_q;
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rsp_q      <= rsp_d;
            busy_q     <= busy_d;
            trig_q     <= trig_d;
            data_q     <= data_d;
            trig_cnt_q <= trig_cnt_d;
            to_cnt_q   <= to_cnt_d;
            to_flag_q  <= to_flag_d;
        end
    end

    assign grant_out       = grant_q;
    assign ack_out         = ack_q;
    assign err_out         = err_q;
    assign rsp_data_out    = rsp_q;
    assign busy_out        = busy_q;
    assign spi_trigger_out = trig_q;
    assign spi_data_out    = data_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: a small SPI master model answers each write with word ^ 0x99,
// and a monitor pops expected acks from a scoreboard queue whenever ack_out fires.
module tb_spi_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [23:0] req_data = '0;
    logic [2:0]  grant, ack;
    logic        err, busy, trig;
    logic [7:0]  rsp, spi_dout;
    logic [7:0]  spi_din = '0;
    logic        model_ready = 1'b1;
    logic        hold_low = 1'b0;
    logic        model_hang = 1'b0;
    logic        spi_ready;

    assign spi_ready = model_ready & ~hold_low;

    always #5 clk = ~clk;

    spi_arbiter #(.TIMEOUT_CYCLES(100)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .req_in          (req),
        .req_data_in     (req_data),
        .grant_out       (grant),
        .ack_out         (ack),
        .err_out         (err),
        .rsp_data_out    (rsp),
        .busy_out        (busy),
        .spi_trigger_out (trig),
        .spi_data_out    (spi_dout),
        .spi_data_in     (spi_din),
        .spi_ready_in    (spi_ready)
    );

    typedef struct packed {
        logic [2:0] ack;
        logic       err;
        logic [7:0] rsp;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] word_q[$];
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output logic [2:0] a);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ack == 3'b000 && n < 400);
        if (ack == 3'b000) begin
            total++;
            bad++;
            $display("FAIL ack_wait: no ack within %0d cycles", n);
        end
        a = ack;
    endtask

    // Scoreboard monitor plus per-cycle output invariants
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
                chk("err_without_ack", 32'(err & (ack == 3'b000)), 32'd0);
                chk("trig_without_busy", 32'(trig & ~busy), 32'd0);
                if (ack != 3'b000) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_ack: got ack=%b, want no ack", ack);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_owner", 32'(ack), 32'(e.ack));
                        chk("ack_err", 32'(err), 32'(e.err));
                        chk("ack_rsp", 32'(rsp), 32'(e.rsp));
                    end
                end
            end
        end
    end

    // SPI master model: shares rst, answers with word ^ 0x99 unless hung
    initial begin : spi_model
        logic [7:0] w;
        int         width;
        logic       prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (trig && !prev && !rst) begin
                w = spi_dout;
                if (word_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_trigger: got word 0x%0h, want no trigger", w);
                end else begin
                    chk("spi_word", 32'(w), 32'(word_q.pop_front()));
                end
                width = 1;
                while (width < 20) begin
                    @(negedge clk);
                    if (trig) width++;
                    else break;
                end
                chk("trig_width", width, 2);
                if (!model_hang) begin
                    for (int i = 0; i < 3 && !rst; i++) @(negedge clk);
                    model_ready = 1'b0;
                    for (int i = 0; i < 5 && !rst; i++) @(negedge clk);
                    spi_din     = w ^ 8'h99;
                    model_ready = 1'b1;
                end
            end
            prev = trig;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [2:0] a;
        int         t, t_trig, seen, n;

        // Reset values
        tick(2);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rsp", 32'(rsp), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_spi_data", 32'(spi_dout), 32'd0);
        rst = 1'b0;
        tick(4);

        // Single requester: req 1 writes 0x3C, model returns 0xA5
        req_data = {8'h00, 8'h3C, 8'h00};
        word_q.push_back(8'h3C);
        exp_q.push_back('{3'b010, 1'b0, 8'hA5});
        req = 3'b010;
        tick(1);
        chk("t1_grant", 32'(grant), 32'(3'b010));
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_spi_data", 32'(spi_dout), 32'h3C);
        chk("t1_trig_not_yet", 32'(trig), 32'd0);
        tick(1);
        chk("t1_trig_high", 32'(trig), 32'd1);
        wait_ack(a);
        req &= ~a;
        chk("t1_busy_at_ack", 32'(busy), 32'd0);
        chk("t1_grant_at_ack", 32'(grant), 32'd0);
        chk("t1_spi_data_held", 32'(spi_dout), 32'h3C);
        tick(3);

        // Contention: all three held from reset
        rst = 1'b1;
        req_data = {8'h33, 8'h22, 8'h11};
        req = 3'b111;
        word_q.push_back(8'h11);
        word_q.push_back(8'h22);
        word_q.push_back(8'h33);
        word_q.push_back(8'h11);
        exp_q.push_back('{3'b001, 1'b0, 8'h88});
        exp_q.push_back('{3'b010, 1'b0, 8'hBB});
        exp_q.push_back('{3'b100, 1'b0, 8'hAA});
        exp_q.push_back('{3'b001, 1'b0, 8'h88});
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) wait_ack(a);
        req = 3'b000;
        tick(3);

        // Fairness: req 0 and req 2 both keep requesting
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        req_data = {8'h0F, 8'h00, 8'h5A};
        word_q.push_back(8'h5A);
        word_q.push_back(8'h0F);
        word_q.push_back(8'h5A);
        word_q.push_back(8'h0F);
        exp_q.push_back('{3'b001, 1'b0, 8'hC3});
        exp_q.push_back('{3'b100, 1'b0, 8'h96});
        exp_q.push_back('{3'b001, 1'b0, 8'hC3});
        exp_q.push_back('{3'b100, 1'b0, 8'h96});
        req = 3'b101;
        for (int i = 0; i < 4; i++) wait_ack(a);
        req = 3'b000;
        tick(3);

        // Timeout: model never drops ready
        model_hang = 1'b1;
        req_data = {8'h00, 8'h00, 8'h77};
        word_q.push_back(8'h77);
        exp_q.push_back('{3'b001, 1'b1, 8'h00});
        req = 3'b001;
        t = 0;
        t_trig = -1;
        do begin
            tick(1);
            t++;
            if (trig && t_trig < 0) t_trig = t;
        end while (ack == 3'b000 && t < 400);
        chk("timeout_latency", t - t_trig, 100);
        chk("timeout_rsp_zero", 32'(rsp), 32'd0);
        chk("timeout_trig_low", 32'(trig), 32'd0);
        req = 3'b000;
        model_hang = 1'b0;
        tick(1);
        req_data = {8'h00, 8'h42, 8'h00};
        word_q.push_back(8'h42);
        exp_q.push_back('{3'b010, 1'b0, 8'hDB});
        req = 3'b010;
        wait_ack(a);
        req &= ~a;
        tick(3);

        // Startup: ready held low after reset with req 2 pending
        rst = 1'b1;
        hold_low = 1'b1;
        req_data = {8'h81, 8'h00, 8'h00};
        req = 3'b100;
        tick(2);
        rst = 1'b0;
        seen = 0;
        repeat (50) begin
            tick(1);
            if (grant != 3'b000) seen++;
        end
        chk("startup_no_grant", seen, 0);
        word_q.push_back(8'h81);
        exp_q.push_back('{3'b100, 1'b0, 8'h18});
        hold_low = 1'b0;
        tick(1);
        chk("startup_grant_e1", 32'(grant), 32'd0);
        tick(1);
        chk("startup_grant_e2", 32'(grant), 32'd0);
        tick(1);
        chk("startup_grant_e3", 32'(grant), 32'(3'b100));
        wait_ack(a);
        req &= ~a;
        tick(3);

        // Reset during WAIT_DONE with req 0 pending
        req_data = {8'h00, 8'h66, 8'h24};
        word_q.push_back(8'h66);
        req = 3'b010;
        tick(1);
        chk("r6_grant", 32'(grant), 32'(3'b010));
        tick(2);
        req = 3'b011;
        n = 0;
        while (spi_ready && n < 100) begin
            tick(1);
            n++;
        end
        chk("r6_ready_dropped", 32'(spi_ready), 32'd0);
        tick(2);
        rst = 1'b1;
        #1;
        chk("r6_grant_clr", 32'(grant), 32'd0);
        chk("r6_ack_clr", 32'(ack), 32'd0);
        chk("r6_err_clr", 32'(err), 32'd0);
        chk("r6_rsp_clr", 32'(rsp), 32'd0);
        chk("r6_busy_clr", 32'(busy), 32'd0);
        chk("r6_trig_clr", 32'(trig), 32'd0);
        chk("r6_spi_data_clr", 32'(spi_dout), 32'd0);
        tick(3);
        rst = 1'b0;
        word_q.push_back(8'h24);
        word_q.push_back(8'h66);
        exp_q.push_back('{3'b001, 1'b0, 8'hBD});
        exp_q.push_back('{3'b010, 1'b0, 8'hFF});
        tick(1);
        chk("r6_no_stale_trig_1", 32'(trig), 32'd0);
        chk("r6_no_grant_1", 32'(grant), 32'd0);
        tick(1);
        chk("r6_no_stale_trig_2", 32'(trig), 32'd0);
        chk("r6_no_grant_2", 32'(grant), 32'd0);
        tick(1);
        chk("r6_first_grant", 32'(grant), 32'(3'b001));
        wait_ack(a);
        req &= ~a;
        wait_ack(a);
        req &= ~a;
        tick(5);

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("words_drained", word_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
